// File: rtl/segre_pkg.sv
// Shared core definitions: memory access sizes, store-buffer entry layout and
// the byte-lane mask used by both the store buffer and the dcache store path.
package segre_pkg;

    localparam int ADDR_SIZE      = 32;
    localparam int WORD_SIZE      = 32;
    localparam int SB_NUM_ENTRIES = 2;

    // Encoding order matters: a larger value means a wider access.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
        memop_data_type_e     data_type;
    } sb_entry_t;

    function automatic logic [3:0] byte_mask(input memop_data_type_e t, input logic [1:0] off);
        logic [3:0] m;
        case (t)
            BYTE:    m = 4'b0001 << off;
            HALF:    m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/segre_store_buffer.sv
// Posted-store FIFO between commit and the dcache write port, with
// store-to-load forwarding and partial-overlap conflict detection.
module segre_store_buffer
    import segre_pkg::*;
#(
    parameter int NUM_ENTRIES = SB_NUM_ENTRIES,
    parameter int ADDR_W      = ADDR_SIZE,
    parameter int DATA_W      = WORD_SIZE
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              st_valid_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  memop_data_type_e  st_type_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  memop_data_type_e  ld_type_i,
    output logic              sb_hit_o,
    output logic [DATA_W-1:0] sb_data_o,
    output logic              sb_conflict_o,
    input  logic              drain_rdy_i,
    output logic              drain_valid_o,
    output logic [ADDR_W-1:0] sb_addr_o,
    output logic [DATA_W-1:0] sb_wdata_o,
    output memop_data_type_e  sb_type_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(NUM_ENTRIES);
    typedef logic [PTR_W-1:0] ptr_t;

    sb_entry_t              entries [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;
    ptr_t                   head_q;
    ptr_t                   tail_q;
    logic [PTR_W:0]         count_q;
    logic                   push;
    logic                   pop;
    sb_entry_t              head_e;

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == (PTR_W+1)'(NUM_ENTRIES));
    assign drain_valid_o = !empty_o;

    // Drain handshake: an entry leaves at the edge where drain_valid_o and
    // drain_rdy_i are both high; a store is taken when st_valid_i is high and
    // there is room, counting the slot freed by a same-cycle drain.
    assign pop  = drain_valid_o && drain_rdy_i;
    assign push = st_valid_i && (!full_o || pop);

    assign head_e     = valid_q[head_q] ? entries[head_q] : '0;
    assign sb_addr_o  = head_e.addr;
    assign sb_wdata_o = head_e.data;
    assign sb_type_o  = head_e.data_type;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) entries[i] <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + ptr_t'(1);
            end
            // When full, tail == head: this later write re-validates the freed slot.
            if (push) begin
                entries[tail_q] <= '{addr: st_addr_i, data: st_data_i, data_type: st_type_i};
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + ptr_t'(1);
            end
            count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    logic [3:0]             ld_mask;
    logic [NUM_ENTRIES-1:0] match;
    ptr_t                   age [NUM_ENTRIES];

    assign ld_mask = byte_mask(ld_type_i, ld_addr_i[1:0]);

    // Age is distance from head, so the youngest entry has the largest age
    // regardless of where the pointers have wrapped to.
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_match
        assign age[g]   = ptr_t'(g) - head_q;
        assign match[g] = valid_q[g]
                       && (entries[g].addr[ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])
                       && |(byte_mask(entries[g].data_type, entries[g].addr[1:0]) & ld_mask);
    end

    logic      found;
    ptr_t      sel_idx;
    ptr_t      best_age;
    sb_entry_t sel;
    logic      exact;

    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        best_age = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            if (match[k] && (!found || age[k] > best_age)) begin
                found    = 1'b1;
                sel_idx  = ptr_t'(k);
                best_age = age[k];
            end
        end
        sel           = entries[sel_idx];
        exact         = (sel.addr == ld_addr_i) && (sel.data_type >= ld_type_i);
        sb_hit_o      = ld_valid_i && found && exact;
        sb_conflict_o = ld_valid_i && found && !exact;
        sb_data_o     = sb_hit_o ? sel.data : '0;
    end

    // Upstream must stall on full_o; a store arriving here would be lost.
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rsn_i)
        !(st_valid_i && full_o && !pop));

endmodule
